// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
//   Multi-cycle integer multiply / divide unit for the execute stage.
//   Radix-2 shift-add multiply and restoring divide, one bit per cycle, on
//   operand magnitudes. Signs are fixed up when the result is registered.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   req          level request, held by EX while a mul/div op is in the stage
//   op           00 MULU, 01 MUL (signed), 10 DIVU, 11 DIV (signed)
//   a, b         multiplicand/dividend, multiplier/divisor
//   flush        abort the current operation (pipeline squash)
//   result_hi    product upper half / remainder
//   result_lo    product lower half / quotient
//   done         one-cycle pulse; results valid now and held afterwards
//   busy         high while in RUN or DONE
//   div_by_zero  qualified by done; divide with b == 0
//   stall        req & ~done
// -----------------------------------------------------------------------------
module muldiv_seq #(
    parameter int WIDTH    = 32,
    parameter int CNT_BITS = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic [1:0]          op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic                flush,
    output logic [WIDTH-1:0]    result_hi,
    output logic [WIDTH-1:0]    result_lo,
    output logic                done,
    output logic                busy,
    output logic                div_by_zero,
    output logic                stall
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q;
    logic [CNT_BITS-1:0]    count_q;
    logic                   is_div_q;     // operation latched in IDLE
    logic                   neg_q;        // negate product / quotient
    logic                   rem_neg_q;    // negate remainder (sign of a)
    logic [WIDTH-1:0]       b_q;          // multiplicand / divisor magnitude
    logic [WIDTH-1:0]       hi_q;         // partial product high / partial remainder
    logic [WIDTH-1:0]       lo_q;         // multiplier bits / dividend-quotient bits
    logic [WIDTH-1:0]       result_hi_q;
    logic [WIDTH-1:0]       result_lo_q;
    logic                   done_q;
    logic                   busy_q;
    logic                   dbz_q;

    // Operand conditioning at issue time
    logic                   op_signed_d;
    logic [WIDTH-1:0]       a_mag_d;
    logic [WIDTH-1:0]       b_mag_d;

    // One iteration of the datapath
    logic [WIDTH:0]         mul_sum_d;
    logic [WIDTH:0]         div_shift_d;
    logic [WIDTH:0]         div_diff_d;
    logic [WIDTH-1:0]       step_hi_d;
    logic [WIDTH-1:0]       step_lo_d;

    // Sign-corrected final result, used on the last iteration
    logic [2*WIDTH-1:0]     prod_d;
    logic [WIDTH-1:0]       fin_hi_d;
    logic [WIDTH-1:0]       fin_lo_d;

    always_comb begin
        op_signed_d = op[0];
        a_mag_d     = (op_signed_d && a[WIDTH-1]) ? -a : a;
        b_mag_d     = (op_signed_d && b[WIDTH-1]) ? -b : b;
    end

    always_comb begin
        mul_sum_d   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        // Partial remainder is always below the divisor, so the shifted value
        // fits in WIDTH+1 bits and bit WIDTH of the difference is a clean borrow.
        div_shift_d = {hi_q, lo_q[WIDTH-1]};
        div_diff_d  = div_shift_d - {1'b0, b_q};

        step_hi_d   = '0;
        step_lo_d   = '0;
        if (is_div_q) begin
            if (!div_diff_d[WIDTH]) begin
                step_hi_d = div_diff_d[WIDTH-1:0];
                step_lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi_d = div_shift_d[WIDTH-1:0];
                step_lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi_d = mul_sum_d[WIDTH:1];
            step_lo_d = {mul_sum_d[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod_d   = {step_hi_d, step_lo_d};
        fin_hi_d = '0;
        fin_lo_d = '0;
        if (is_div_q) begin
            // Negating zero yields zero, so no negative-zero handling is needed.
            // MIN / -1 gives magnitude 2^(WIDTH-1), whose negation is MIN again.
            fin_lo_d = neg_q     ? -step_lo_d : step_lo_d;
            fin_hi_d = rem_neg_q ? -step_hi_d : step_hi_d;
        end else begin
            if (neg_q) begin
                prod_d = -prod_d;
            end
            fin_hi_d = prod_d[2*WIDTH-1:WIDTH];
            fin_lo_d = prod_d[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            is_div_q    <= 1'b0;
            neg_q       <= 1'b0;
            rem_neg_q   <= 1'b0;
            b_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            result_hi_q <= '0;
            result_lo_q <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else if (flush) begin
            // Results and div_by_zero intentionally keep their last values.
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (req) begin
                        is_div_q  <= op[1];
                        neg_q     <= op_signed_d & (a[WIDTH-1] ^ b[WIDTH-1]);
                        rem_neg_q <= op_signed_d & a[WIDTH-1];
                        busy_q    <= 1'b1;
                        if (op[1] && (b == '0)) begin
                            // Remainder is the raw dividend for both signednesses.
                            result_hi_q <= a;
                            result_lo_q <= '1;
                            dbz_q       <= 1'b1;
                            done_q      <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            b_q     <= b_mag_d;
                            hi_q    <= '0;
                            lo_q    <= a_mag_d;
                            count_q <= '0;
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    hi_q    <= step_hi_d;
                    lo_q    <= step_lo_d;
                    count_q <= count_q + CNT_BITS'(1);
                    if (count_q == CNT_BITS'(WIDTH-1)) begin
                        result_hi_q <= fin_hi_d;
                        result_lo_q <= fin_lo_d;
                        dbz_q       <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Always return to IDLE: req still high here belongs to
                    // the instruction that just completed.
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign result_hi   = result_hi_q;
    assign result_lo   = result_lo_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign div_by_zero = dbz_q;
    assign stall       = req & ~done_q;

endmodule
